alu_ctrl_seq: RTL and testbench

//  Producer end of the ALU ctrl_i interface. It sits in the EX stage ahead of the ALU.
//  It decodes the main-decoder ALUOp plus instruction funct into the 4-bit ALU control code
//  and holds that code in a registered output with a valid/ready handshake.
//  For MULT it holds ctrl_o steady for MULT_LAT extra cycles, so the slow ALU multiply
//  can be timed as a multicycle path.

---
 rtl/alu_ctrl_pkg.sv | 42 ++++
 rtl/alu_ctrl_decode.sv | 44 ++++
 rtl/alu_ctrl_seq.sv | 112 +++++++++++
 tb/tb_alu_ctrl_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared constants for the EX-stage ALU control producer and the ALU itself:
//   main-decoder ALUOp codes, R-type funct codes, 4-bit ALU control codes and
//   the sequencer state encoding.
package alu_ctrl_pkg;

  // Main-decoder ALUOp codes (5..7 are illegal)
  localparam logic [2:0] ALUOP_MEM   = 3'd0;
  localparam logic [2:0] ALUOP_BEQ   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_ADDI  = 3'd3;
  localparam logic [2:0] ALUOP_SLTI  = 3'd4;

  // R-type funct field values
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_MULT = 6'h18;

  // ALU control codes
  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_OR   = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_MUL  = 4'd3;
  localparam logic [3:0] C_SLTI = 4'd5;
  localparam logic [3:0] C_SUB  = 4'd6;
  localparam logic [3:0] C_SLT  = 4'd7;
  localparam logic [3:0] C_ADDI = 4'd8;
  localparam logic [3:0] C_NOR  = 4'd12;
  localparam logic [3:0] C_NONE = 4'd15;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MWAIT = 2'd1,
    ST_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
//   Purely combinational ALU control decoder.
//   Ports:
//     aluop   in  3  main-decoder ALUOp
//     funct   in  6  R-type funct field (used only for ALUOP_RTYPE)
//     ctrl    out 4  ALU control code (C_NONE when undecodable)
//     illegal out 1  op is undecodable
//     is_mult out 1  op is the multicycle multiply
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal,
  output logic       is_mult
);

  always_comb begin
    ctrl    = C_NONE;
    illegal = 1'b1;
    is_mult = 1'b0;
    case (aluop)
      ALUOP_MEM:  begin ctrl = C_ADD;  illegal = 1'b0; end
      ALUOP_BEQ:  begin ctrl = C_SUB;  illegal = 1'b0; end
      ALUOP_ADDI: begin ctrl = C_ADDI; illegal = 1'b0; end
      ALUOP_SLTI: begin ctrl = C_SLTI; illegal = 1'b0; end
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD:  begin ctrl = C_ADD; illegal = 1'b0; end
          F_SUB:  begin ctrl = C_SUB; illegal = 1'b0; end
          F_AND:  begin ctrl = C_AND; illegal = 1'b0; end
          F_OR:   begin ctrl = C_OR;  illegal = 1'b0; end
          F_SLT:  begin ctrl = C_SLT; illegal = 1'b0; end
          F_NOR:  begin ctrl = C_NOR; illegal = 1'b0; end
          F_MULT: begin ctrl = C_MUL; illegal = 1'b0; is_mult = 1'b1; end
          default: begin ctrl = C_NONE; illegal = 1'b1; end
        endcase
      end
      default: begin ctrl = C_NONE; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
//   EX-stage producer of the ALU control code. Decodes ALUOp/funct, registers
//   the control code behind a valid/ready handshake, and for MULT holds the
//   code for MULT_LAT extra cycles before raising out_valid_o.
//   Ports:
//     clk_i        in  1  clock
//     rst_i        in  1  synchronous active-high reset
//     flush_i      in  1  synchronous flush, discards any in-flight op
//     in_valid_i   in  1  aluop_i/funct_i valid
//     in_ready_o   out 1  op accepted this cycle when in_valid_i is high
//     aluop_i      in  3  main-decoder ALUOp
//     funct_i      in  6  R-type funct field
//     ctrl_o       out 4  registered ALU control code
//     illegal_o    out 1  op was undecodable (qualified by out_valid_o)
//     out_valid_o  out 1  ctrl_o/illegal_o valid
//     out_ready_i  in  1  downstream consumes the op
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  localparam logic [3:0] LAT4 = 4'(MULT_LAT);

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       dec_is_mult;
  logic       accept;

  state_t     state_p1;
  logic [3:0] ctrl_p1;
  logic       ill_p1;
  logic       vld_p1;
  logic [3:0] cnt_p1;

  // Stage p0: combinational decode and handshake
  alu_ctrl_decode u_decode (
    .aluop   (aluop_i),
    .funct   (funct_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_mult (dec_is_mult)
  );

  assign in_ready_o = !flush_i &&
                      ((state_p1 == ST_IDLE) || ((state_p1 == ST_VALID) && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;

  // Stage p1: registered control code, valid and multiply hold counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1 <= ST_IDLE;
      ctrl_p1  <= C_NONE;
      ill_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      cnt_p1   <= 4'd0;
    end else if (flush_i) begin
      state_p1 <= ST_IDLE;
      vld_p1   <= 1'b0;
      cnt_p1   <= 4'd0;
    end else begin
      case (state_p1)
        ST_IDLE, ST_VALID: begin
          if (accept) begin
            ctrl_p1 <= dec_ctrl;
            ill_p1  <= dec_illegal;
            if (dec_is_mult && (MULT_LAT != 0)) begin
              state_p1 <= ST_MWAIT;
              cnt_p1   <= LAT4;
              vld_p1   <= 1'b0;
            end else begin
              state_p1 <= ST_VALID;
              vld_p1   <= 1'b1;
            end
          end else if ((state_p1 == ST_VALID) && out_ready_i) begin
            state_p1 <= ST_IDLE;
            vld_p1   <= 1'b0;
          end
        end
        ST_MWAIT: begin
          cnt_p1 <= cnt_p1 - 4'd1;
          if (cnt_p1 == 4'd1) begin
            state_p1 <= ST_VALID;
            vld_p1   <= 1'b1;
          end
        end
        default: begin
          state_p1 <= ST_IDLE;
          vld_p1   <= 1'b0;
          cnt_p1   <= 4'd0;
        end
      endcase
    end
  end

  assign ctrl_o      = ctrl_p1;
  assign illegal_o   = ill_p1;
  assign out_valid_o = vld_p1;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq
//   Two instances (MULT_LAT=2 and MULT_LAT=0) run in lockstep, each against
//   its own behavioural model: an op is either waiting out a countdown,
//   presented as valid, or absent.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [2];
  logic       flush     [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [2:0] aluop     [2];
  logic [5:0] funct     [2];
  logic [3:0] ctrl      [2];
  logic       illegal   [2];
  logic       out_valid [2];
  logic       out_ready [2];

  alu_ctrl_seq #(.MULT_LAT(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst[0]), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .aluop_i(aluop[0]), .funct_i(funct[0]),
    .ctrl_o(ctrl[0]), .illegal_o(illegal[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0])
  );

  alu_ctrl_seq #(.MULT_LAT(0)) u_lat0 (
    .clk_i(clk), .rst_i(rst[1]), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .aluop_i(aluop[1]), .funct_i(funct[1]),
    .ctrl_o(ctrl[1]), .illegal_o(illegal[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1])
  );

  // Reference model state per instance
  bit         m_vld  [2];
  logic [3:0] m_ctrl [2];
  bit         m_ill  [2];
  int         m_wait [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic [5:0] flist [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h18, 6'h18, 6'h18};

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic void ref_decode(input logic [2:0] op, input logic [5:0] fn,
                                     output logic [3:0] c, output bit il, output bit mu);
    c = 4'd15; il = 1'b1; mu = 1'b0;
    case (op)
      3'd0: begin c = 4'd2; il = 1'b0; end
      3'd1: begin c = 4'd6; il = 1'b0; end
      3'd3: begin c = 4'd8; il = 1'b0; end
      3'd4: begin c = 4'd5; il = 1'b0; end
      3'd2: begin
        il = 1'b0;
        case (fn)
          6'h20: c = 4'd2;
          6'h22: c = 4'd6;
          6'h24: c = 4'd0;
          6'h25: c = 4'd1;
          6'h2A: c = 4'd7;
          6'h27: c = 4'd12;
          6'h18: begin c = 4'd3; mu = 1'b1; end
          default: begin c = 4'd15; il = 1'b1; end
        endcase
      end
      default: ;
    endcase
  endfunction

  task automatic set_in(input bit r, input bit f, input bit v, input logic [2:0] op,
                        input logic [5:0] fn, input bit ordy);
    for (int k = 0; k < 2; k++) begin
      rst[k] = r; flush[k] = f; in_valid[k] = v;
      aluop[k] = op; funct[k] = fn; out_ready[k] = ordy;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic run_cycle();
    bit rdy;
    logic [3:0] c;
    bit il, mu;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy = !flush[k] && ((!m_vld[k] && m_wait[k] == 0) || (m_vld[k] && out_ready[k]));
      chk($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(rdy));
      if (rst[k]) begin
        m_vld[k] = 0; m_ctrl[k] = 4'd15; m_ill[k] = 0; m_wait[k] = 0;
      end else if (flush[k]) begin
        m_vld[k] = 0; m_wait[k] = 0;
      end else if (in_valid[k] && rdy) begin
        ref_decode(aluop[k], funct[k], c, il, mu);
        m_ctrl[k] = c; m_ill[k] = il;
        if (mu && lat_of(k) > 0) begin
          m_wait[k] = lat_of(k); m_vld[k] = 0;
        end else begin
          m_wait[k] = 0; m_vld[k] = 1;
        end
      end else if (m_wait[k] > 0) begin
        m_wait[k]--;
        if (m_wait[k] == 0) m_vld[k] = 1;
      end else if (m_vld[k] && out_ready[k]) begin
        m_vld[k] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ctrl[%0d]", k),      32'(ctrl[k]),      32'(m_ctrl[k]));
      chk($sformatf("illegal[%0d]", k),   32'(illegal[k]),   32'(m_ill[k]));
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_vld[k]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 3'($urandom), 6'($urandom), 1);
      run_cycle();
    end
  endtask

  task automatic mult_op();
    set_in(0, 0, 1, 3'd2, 6'h18, 1);
    run_cycle();
  endtask

  initial begin
    set_in(1, 0, 0, 3'd0, 6'd0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 0; m_ctrl[k] = 4'd15; m_ill[k] = 0; m_wait[k] = 0;
      chk($sformatf("rst_ctrl[%0d]", k),  32'(ctrl[k]),      32'd15);
      chk($sformatf("rst_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst_ill[%0d]", k),   32'(illegal[k]),   32'd0);
    end
    set_in(0, 0, 0, 3'd0, 6'd0, 1);
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("rst_ready[%0d]", k), 32'(in_ready[k]), 32'd1);
    @(negedge clk);

    // Decode sweep, back-to-back
    foreach (flist[i]) if (i < 6) begin
      set_in(0, 0, 1, 3'd2, flist[i], 1);
      run_cycle();
    end
    for (int op = 0; op < 5; op++) if (op != 2) begin
      set_in(0, 0, 1, 3'(op), 6'($urandom), 1);
      run_cycle();
    end
    idle(1);

    // Multiply latency
    mult_op();
    idle(4);

    // Backpressure then no-bubble handover
    set_in(0, 0, 1, 3'd1, 6'd0, 1); run_cycle();
    repeat (3) begin set_in(0, 0, 1, 3'd0, 6'd0, 0); run_cycle(); end
    set_in(0, 0, 1, 3'd0, 6'd0, 1); run_cycle();
    idle(1);

    // Illegal ops
    set_in(0, 0, 1, 3'd2, 6'h3F, 1); run_cycle();
    set_in(0, 0, 1, 3'd6, 6'h20, 1); run_cycle();
    idle(1);

    // Flush in first MWAIT cycle, flush against accept in IDLE
    mult_op();
    set_in(0, 1, 0, 3'd0, 6'd0, 1); run_cycle();
    idle(3);
    set_in(0, 1, 1, 3'd0, 6'h20, 1); run_cycle();
    idle(1);

    // Reset during MWAIT
    mult_op();
    set_in(1, 0, 0, 3'd0, 6'd0, 1); run_cycle();
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]       = ($urandom_range(0, 59) == 0);
        flush[k]     = ($urandom_range(0, 9) == 0);
        in_valid[k]  = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 3) != 0);
        aluop[k]     = ($urandom_range(0, 9) < 4) ? 3'd2 : 3'($urandom_range(0, 7));
        funct[k]     = ($urandom_range(0, 4) == 0) ? 6'($urandom) : flist[$urandom_range(0, 8)];
      end
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
